// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing from the 50 MHz clock using a divide-by-2 pixel enable.
// Optional STEP_MODE_EN macro adds a debounced step button that can drive game_tick.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
`ifdef STEP_MODE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 500_000
`endif
) (
    input  logic       clk_50mhz,
    input  logic       rst,
`ifdef STEP_MODE_EN
    input  logic       step_mode,
    input  logic       step_btn,
`endif
    output logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_tick,
    output logic       game_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] V_VIS_M1 = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       pix_phase_q, pix_phase_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       frame_tick_q, frame_tick_d;

    always_comb begin
        pix_phase_d  = ~pix_phase_q;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        frame_tick_d = 1'b0;
        if (pix_phase_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            // Tick lands in the cycle the counters first read (0, V_VISIBLE).
            frame_tick_d = (h_cnt_q == H_LAST) && (v_cnt_q == V_VIS_M1);
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            pix_phase_q  <= 1'b0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            pix_phase_q  <= pix_phase_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pix_en     = pix_phase_q;
    assign hsync      = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    assign vsync      = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    assign video_on   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign x          = video_on ? h_cnt_q : '0;
    assign y          = video_on ? v_cnt_q : '0;
    assign frame_tick = frame_tick_q;

`ifdef STEP_MODE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q, last_q;
    logic            deb_q, deb_d, deb_prev_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press;

    // Counter restarts whenever the synchronised level changes; the debounced
    // level only follows once the count has run out on an unchanged level.
    always_comb begin
        db_cnt_d = db_cnt_q;
        deb_d    = deb_q;
        if (sync2_q != last_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q != DB_LAST) begin
            db_cnt_d = db_cnt_q + 1'b1;
        end else begin
            deb_d = last_q;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            last_q     <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            sync1_q    <= step_btn;
            sync2_q    <= sync1_q;
            last_q     <= sync2_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            db_cnt_q   <= db_cnt_d;
        end
    end

    assign press     = deb_q & ~deb_prev_q;
    assign game_tick = step_mode ? press : frame_tick_q;
`else
    assign game_tick = frame_tick_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: real horizontal geometry, shortened vertical geometry.
// Reference model derives every output from the clock count since the last reset.
module tb_vga_timing_gen;

    localparam int HT = 800;
    localparam int VV = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en, hsync, vsync, video_on, frame_tick, game_tick;
    logic [9:0] x, y;
`ifdef STEP_MODE_EN
    logic step_mode = 1'b0;
    logic step_btn  = 1'b0;
    int   gt_cnt    = 0;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int k = 0;
    bit model_valid = 1'b0;

    vga_timing_gen #(
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
`ifdef STEP_MODE_EN
        , .DEBOUNCE_CYCLES(8)
`endif
    ) dut (
        .clk_50mhz (clk),
        .rst       (rst),
`ifdef STEP_MODE_EN
        .step_mode (step_mode),
        .step_btn  (step_btn),
`endif
        .pix_en    (pix_en),
        .hsync     (hsync),
        .vsync     (vsync),
        .video_on  (video_on),
        .x         (x),
        .y         (y),
        .frame_tick(frame_tick),
        .game_tick (game_tick)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Clock edges since the last edge that sampled rst high.
    always @(posedge clk) begin
        if (rst) begin
            k           <= 0;
            model_valid <= 1'b1;
        end else begin
            k <= k + 1;
        end
    end

    always @(negedge clk) begin : cmp
        int p, h, v;
        logic e_pe, e_hs, e_vs, e_vo, e_ft;
        logic [9:0] e_x, e_y;
        if (model_valid) begin
            p    = (k / 2) % FT;
            h    = p % HT;
            v    = p / HT;
            e_pe = (k % 2) == 1;
            e_vo = (h < 640) && (v < VV);
            e_hs = !((h >= 656) && (h < 752));
            e_vs = !((v >= VV + VF) && (v < VV + VF + VS));
            e_x  = e_vo ? 10'(h) : 10'd0;
            e_y  = e_vo ? 10'(v) : 10'd0;
            e_ft = (k > 0) && (k % 2 == 0) && ((k / 2) % FT == VV * HT);
            chk("cycle", 32'({pix_en, hsync, vsync, video_on, frame_tick, x, y}),
                32'({e_pe, e_hs, e_vs, e_vo, e_ft, e_x, e_y}));
`ifdef STEP_MODE_EN
            if (!step_mode) chk("game_tick_eq_frame", 32'(game_tick), 32'(e_ft));
            else if (game_tick) gt_cnt++;
`else
            chk("game_tick_eq_frame", 32'(game_tick), 32'(e_ft));
`endif
        end
    end

    initial begin
        int c, hs_f0, hs_f1, hs_r0, vo_f0, x_max, ft0, ft1, vs_f0, vs_r0;
        logic p_hs, p_vs, p_vo;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_pix_en", 32'(pix_en), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_video_on", 32'(video_on), 1);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_frame_tick", 32'(frame_tick), 0);
        chk("rst_game_tick", 32'(game_tick), 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("pix_en_pattern", 32'(pix_en), 32'(i % 2));
        end

        c = 4;
        hs_f0 = -1; hs_f1 = -1; hs_r0 = -1; vo_f0 = -1;
        ft0 = -1; ft1 = -1; vs_f0 = -1; vs_r0 = -1; x_max = 0;
        p_hs = hsync; p_vs = vsync; p_vo = video_on;
        while (c < 20000) begin
            @(negedge clk);
            c++;
            if (!hsync && p_hs) begin
                if (hs_f0 < 0) hs_f0 = c;
                else if (hs_f1 < 0) hs_f1 = c;
            end
            if (hsync && !p_hs && hs_r0 < 0) hs_r0 = c;
            if (!video_on && p_vo && vo_f0 < 0) vo_f0 = c;
            if (c < 1600 && int'(x) > x_max) x_max = int'(x);
            if (frame_tick) begin
                if (ft0 < 0) ft0 = c;
                else if (ft1 < 0) ft1 = c;
            end
            if (!vsync && p_vs && vs_f0 < 0) vs_f0 = c;
            if (vsync && !p_vs && vs_r0 < 0) vs_r0 = c;
            p_hs = hsync; p_vs = vsync; p_vo = video_on;
        end
        chk("hsync_fall_h656", hs_f0, 1312);
        chk("line_period", hs_f1 - hs_f0, 1600);
        chk("hsync_low_len", hs_r0 - hs_f0, 192);
        chk("video_off_h640", vo_f0, 1280);
        chk("x_max", x_max, 639);
        chk("frame_tick_first", ft0, 6400);
        chk("frame_period", ft1 - ft0, 12800);
        chk("vsync_fall_v5", vs_f0, 8000);
        chk("vsync_low_len", vs_r0 - vs_f0, 3200);

        c = 0;
        while (c < 20000 && !(video_on && x == 10'd300 && y == 10'd2)) begin
            @(negedge clk);
            c++;
        end
        chk("reach_h300_v2", 32'(c < 20000), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_x", 32'(x), 0);
        chk("midrst_y", 32'(y), 0);
        chk("midrst_pix_en", 32'(pix_en), 0);
        chk("midrst_frame_tick", 32'(frame_tick), 0);
        c = 0;
        while (c < 20000 && !frame_tick) begin
            @(negedge clk);
            c++;
        end
        chk("midrst_next_frame_tick", c, 6400);

`ifdef STEP_MODE_EN
        @(posedge clk);
        #2 step_mode = 1'b1;
        gt_cnt = 0;
        @(negedge clk);
        repeat (3) begin
            step_btn = 1'b1;
            repeat (3) @(negedge clk);
            step_btn = 1'b0;
            repeat (12) @(negedge clk);
        end
        chk("glitch_no_tick", gt_cnt, 0);
        step_btn = 1'b1;
        repeat (20) @(negedge clk);
        step_btn = 1'b0;
        repeat (20) @(negedge clk);
        chk("press_one_tick", gt_cnt, 1);
        repeat (13000) @(negedge clk);
        chk("frames_no_tick", gt_cnt, 1);
        @(posedge clk);
        #2 step_mode = 1'b0;
        @(negedge clk);
        step_btn = 1'b1;
        repeat (20) @(negedge clk);
        step_btn = 1'b0;
        repeat (20) @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
